// File: rtl/rs_pkg.sv
// rs_pkg -- shared definitions for the RS(204,188) encoder and syndrome blocks.
//   N, K, NPAR   : codeword length, message length, parity symbol count
//   PRIM_POLY    : GF(256) field polynomial x^8+x^4+x^3+x^2+1
//   GEN[0..15]   : generator coefficients g0..g15 of
//                  g(x) = (x+a^0)(x+a^1)...(x+a^15), g16 = 1 implicit
//   rs_state_e   : encoder FSM states
//   gf_xtime / gf_mul_alpha_pow : constant-only helpers used to build XOR trees
package rs_pkg;

    localparam int N    = 204;
    localparam int K    = 188;
    localparam int NPAR = 16;

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    localparam logic [7:0] GEN [NPAR] = '{
        8'h3B, 8'h24, 8'h32, 8'h62, 8'hE5, 8'h29, 8'h41, 8'hA3,
        8'h08, 8'h1E, 8'hD1, 8'h44, 8'hBD, 8'h68, 8'h0D, 8'h3B
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rs_state_e;

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? PRIM_POLY[7:0] : 8'h00);
    endfunction

    // c * alpha^n, evaluated at elaboration time only.
    function automatic logic [7:0] gf_mul_alpha_pow(input logic [7:0] c, input int n);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < n; i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_encoder_if.sv
// rs_encoder_if -- byte stream bundle around the RS encoder.
//   Msg_In/In_Valid/In_Ready : upstream message bytes, transfer = In_Valid & In_Ready
//   Code_Out/Out_Valid       : codeword bytes, no backpressure
//   Out_Sop/Out_Eop          : first / last byte of each 204-byte codeword
// master = the environment (source of messages, sink of codewords)
// slave  = the encoder
interface rs_encoder_if;

    logic [7:0] Msg_In;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] Code_Out;
    logic       Out_Valid;
    logic       Out_Sop;
    logic       Out_Eop;

    modport master (
        output Msg_In,
        output In_Valid,
        input  In_Ready,
        input  Code_Out,
        input  Out_Valid,
        input  Out_Sop,
        input  Out_Eop
    );

    modport slave (
        input  Msg_In,
        input  In_Valid,
        output In_Ready,
        output Code_Out,
        output Out_Valid,
        output Out_Sop,
        output Out_Eop
    );

endinterface

// File: rtl/gf_const_mult.sv
// gf_const_mult -- GF(256) multiply by a fixed constant.
//   a_i   : 8-bit field element
//   p_o   : a_i * CONST, a pure XOR tree
//   CONST : constant multiplicand
// Column i of the multiply matrix is CONST * alpha^i; the product is the XOR
// of the columns selected by the set bits of a_i.
module gf_const_mult #(
    parameter logic [7:0] CONST = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);
    import rs_pkg::*;

    logic [7:0] term [8];

    for (genvar i = 0; i < 8; i++) begin : g_col
        localparam logic [7:0] COL = gf_mul_alpha_pow(CONST, i);
        assign term[i] = a_i[i] ? COL : 8'h00;
    end

    always_comb begin
        p_o = 8'h00;
        for (int i = 0; i < 8; i++) begin
            p_o = p_o ^ term[i];
        end
    end

endmodule

// File: rtl/rs_encoder.sv
// rs_encoder -- systematic shortened RS(204,188) encoder, t = 8.
//   Clk   : sole clock, rising edge
//   Reset : synchronous, active low
//   bus   : rs_encoder_if.slave (message bytes in, codeword bytes out)
// Message bytes are forwarded with one cycle of latency while a 16-stage LFSR
// divides by g(x); the parity bytes follow immediately from R15.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for the first byte of a frame, LFSR all zero
// DATA   | accepting message bytes 2..188, gaps allowed
// PARITY | shifting out R15 for 16 cycles, input stalled
module rs_encoder
    import rs_pkg::*;
(
    input  logic    Clk,
    input  logic    Reset,
    rs_encoder_if.slave bus
);

    localparam logic [7:0] LAST_MSG = 8'(K - 1);
    localparam logic [7:0] LAST_CW  = 8'(N - 1);

    rs_state_e  state_q;
    logic [7:0] count_q;
    logic [7:0] par_q [NPAR];
    logic [7:0] par_d [NPAR];
    logic [7:0] code_q;
    logic       valid_q;
    logic       sop_q;
    logic       eop_q;
    logic       ready_q;

    logic       accept;
    logic [7:0] fb;
    logic [7:0] gfb [NPAR];

    assign accept = bus.In_Valid & ready_q;
    assign fb     = bus.Msg_In ^ par_q[NPAR-1];

    for (genvar k = 0; k < NPAR; k++) begin : g_mult
        gf_const_mult #(.CONST(GEN[k])) u_mult (
            .a_i (fb),
            .p_o (gfb[k])
        );
    end

    // One LFSR step for an accepted message byte.
    always_comb begin
        par_d[0] = gfb[0];
        for (int k = 1; k < NPAR; k++) begin
            par_d[k] = par_q[k-1] ^ gfb[k];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= 8'd0;
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k < NPAR; k++) begin
                par_q[k] <= 8'h00;
            end
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            case (state_q)
                IDLE, DATA: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        code_q  <= bus.Msg_In;
                        valid_q <= 1'b1;
                        sop_q   <= (count_q == 8'd0);
                        count_q <= count_q + 8'd1;
                        for (int k = 0; k < NPAR; k++) begin
                            par_q[k] <= par_d[k];
                        end
                        if (count_q == LAST_MSG) begin
                            state_q <= PARITY;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                PARITY: begin
                    code_q  <= par_q[NPAR-1];
                    valid_q <= 1'b1;
                    eop_q   <= (count_q == LAST_CW);
                    par_q[0] <= 8'h00;
                    for (int k = 1; k < NPAR; k++) begin
                        par_q[k] <= par_q[k-1];
                    end
                    if (count_q == LAST_CW) begin
                        state_q <= IDLE;
                        count_q <= 8'd0;
                        ready_q <= 1'b1;
                        for (int k = 0; k < NPAR; k++) begin
                            par_q[k] <= 8'h00;
                        end
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= 8'd0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.In_Ready  = ready_q;
    assign bus.Code_Out  = code_q;
    assign bus.Out_Valid = valid_q;
    assign bus.Out_Sop   = sop_q;
    assign bus.Out_Eop   = eop_q;

endmodule
